// File: rtl/hazard_forward_ctrl.sv
// Forwarding/hazard controller: shadow pipeline of destination tags driving
// EX operand forwarding selects, an ID load-use stall and a stall counter.
module hazard_forward_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_AVAIL = 3,
    parameter int unsigned SEL_W      = $clog2(DEPTH),
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_use,
    input  logic             id_rt_use,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_valid [1:DEPTH];
    logic             r_wen   [1:DEPTH];
    logic             r_load  [1:DEPTH];
    logic [REG_W-1:0] r_dst   [1:DEPTH];
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_issue;

    // Forward selects: scan oldest to youngest so the youngest producer overrides.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int unsigned j = DEPTH; j >= 2; j--) begin
            if (r_valid[j] && r_wen[j] && (r_dst[j] == r_ex_rs) && (r_ex_rs != '0))
                fwd_a_sel = (r_load[j] && (j < LOAD_AVAIL)) ? '0 : SEL_W'(j - 1);
            if (r_valid[j] && r_wen[j] && (r_dst[j] == r_ex_rt) && (r_ex_rt != '0))
                fwd_b_sel = (r_load[j] && (j < LOAD_AVAIL)) ? '0 : SEL_W'(j - 1);
        end
        if (!r_valid[1]) begin
            fwd_a_sel = '0;
            fwd_b_sel = '0;
        end
    end

    // Load-use: the youngest producer in the not-yet-forwardable window decides.
    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        for (int unsigned k = LOAD_AVAIL - 2; k >= 1; k--) begin
            if (r_valid[k] && r_wen[k] && (r_dst[k] == id_rs) && (id_rs != '0))
                w_stall_rs = r_load[k];
            if (r_valid[k] && r_wen[k] && (r_dst[k] == id_rt) && (id_rt != '0))
                w_stall_rt = r_load[k];
        end
    end

    assign stall     = id_valid && !flush &&
                       ((w_stall_rs && id_rs_use) || (w_stall_rt && id_rt_use));
    assign w_issue   = id_valid && !stall && !flush;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_wen[k]   <= 1'b0;
                r_load[k]  <= 1'b0;
                r_dst[k]   <= '0;
            end
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            for (int unsigned k = DEPTH; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_wen[k]   <= r_wen[k-1];
                r_load[k]  <= r_load[k-1];
                r_dst[k]   <= r_dst[k-1];
            end
            r_valid[1] <= w_issue;
            r_wen[1]   <= w_issue && id_wen;
            r_load[1]  <= w_issue && id_load;
            r_dst[1]   <= id_dst;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised forwarding and hazard controller for the pipelined MIPS core. It supersedes the fixed three-register forwarding decode.
- Keeps its own shadow pipeline of destination tags, one slot per downstream stage (slot 1 = EX, 2 = MEM, 3 = WB at default depth).
- Produces per-operand forwarding selects for the instruction in EX and a load-use stall for the instruction in ID.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_W, 5: register index width.
- DEPTH, 3: number of tracked slots (EX..last writeback stage); must be >= 2.
- LOAD_AVAIL, 3: lowest slot index from which load data may be forwarded; range 2..DEPTH.
- SEL_W, clog2(DEPTH): width of each forwarding select.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  ID source A index.
- id_rt  in  REG_W  ID source B index.
- id_rs_use  in  1  ID actually reads rs.
- id_rt_use  in  1  ID actually reads rt.
- id_dst  in  REG_W  ID destination index.
- id_wen  in  1  ID writes the register file.
- id_load  in  1  ID is a load.
- flush  in  1  kill ID instruction (branch/jump redirect).
- hold  in  1  global pipeline freeze.
- stall  out  1  load-use stall request to IF/ID.
- fwd_a_sel  out  SEL_W  EX operand A source: 0 = register file, n = result of slot n+1.
- fwd_b_sel  out  SEL_W  EX operand B source, same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst=1): all slots invalid, stall_cnt=0. Hence fwd_a_sel=0, fwd_b_sel=0, stall=0. Reset mid-operation discards all in-flight tags immediately.
- Slot k contents: valid, dst, wen, load. Slot 1 additionally holds rs, rt, rs_use, rt_use of the EX instruction.
- Advance, every rising clk with hold=0:
  - slot k <= slot k-1 for k = 2..DEPTH; slot DEPTH content retires.
  - slot 1 <= ID fields with valid=1 if id_valid & ~stall & ~flush; otherwise a bubble (valid=0, wen=0, load=0).
- hold=1: every slot keeps its value, stall_cnt holds, outputs are recomputed from the held state.
- Producer match, slot k vs index X: valid & wen & dst==X & X!=0. Register 0 never matches.
- Forward select (combinational from slots only, no ID inputs):
  - For slot-1 rs: find the smallest j in 2..DEPTH that matches. The youngest producer wins.
  - Match found and (slot j not a load or j >= LOAD_AVAIL): fwd_a_sel = j-1. Otherwise fwd_a_sel = 0.
  - fwd_b_sel: same rule using slot-1 rt.
  - slot 1 invalid: both selects 0.
  - Use flags do not gate selects.
- Load-use stall (combinational):
  - stall=1 if id_valid & ~flush and, for some k in 1..LOAD_AVAIL-2, slot k is a load matching id_rs (with id_rs_use) or id_rt (with id_rt_use).
  - Only the youngest matching slot is considered. If a non-load in a younger slot matches the same index, there is no stall for that operand.
  - LOAD_AVAIL=2: stall is constant 0.
- Stall effect: a bubble enters slot 1 and ID is held upstream. Stall deasserts once the load reaches slot LOAD_AVAIL-1.
- Flush with stall condition: flush wins; stall=0, a bubble is inserted.
- stall_cnt increments on each clk edge with stall=1 & hold=0. It saturates at all-ones and never wraps.
- Producer retired past slot DEPTH: no forwarding. The register file is write-before-read, so sel=0 is correct.

Test Plan:
- Default params. add r3 then dependent sub reading r3 back-to-back -> EX cycle of sub: fwd_a_sel=1, stall=0. With one NOP between: fwd_a_sel=2.
- lw r5 followed directly by add r6,r5,r5 -> exactly one stall cycle, stall_cnt=1. Next cycle fwd_a_sel=fwd_b_sel=2.
- Two producers of r4 in slots 2 and 3, consumer reads r4 -> fwd_a_sel=1 (youngest). Writes to r0 with consumer of r0 -> sel=0, no stall.
- Load-use condition with flush=1 same cycle -> stall=0, bubble enters slot 1, stall_cnt unchanged.
- hold=1 for 3 cycles during a load-use stall -> slots frozen, stall stays 1, stall_cnt unchanged. Release -> one increment, normal progress.
- rst pulse asynchronously between edges while slots are full -> immediately stall=0, sels=0, stall_cnt=0. DEPTH=5, LOAD_AVAIL=4: load + dependent instruction -> 2 stall cycles, then sel=3.
